occupancy_neighbourhood_reader: RTL and testbench
=================================================

# occupancy_neighbourhood_reader

Read-side companion to the occupancy-grid write datapath: accepts a cell coordinate (x, y), fetches the 2×2 neighbourhood (x,y), (x+1,y), (x,y+1), (x+1,y+1) from the grid RAM's read port, and returns all four cells plus their sum in one response beat. The scan matcher uses it to pull interpolation corners from the 32×16 occupancy grid. Valid/ready handshakes on both request and response.

## Interface
- X_WIDTH, 5, grid x index width (32 columns)
- Y_WIDTH, 4, grid y index width (16 rows)
- CELL_WIDTH, 8, cell width; unsigned log-odds count
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_x  in  X_WIDTH  base x index
- req_y  in  Y_WIDTH  base y index
- mem_read_enable  out  1  read strobe to grid RAM
- mem_address  out  X_WIDTH+Y_WIDTH  read address, computed as y*32 + x, i.e. {y, x}
- mem_data  in  CELL_WIDTH  RAM read data, valid one cycle after address/strobe
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_c00, resp_c10, resp_c01, resp_c11  out  CELL_WIDTH each  cells (x,y), (x+1,y), (x,y+1), (x+1,y+1)
- resp_sum  out  CELL_WIDTH+2  unsigned sum of the four cells
- resp_edge  out  2  bit0: x+1 clamped; bit1: y+1 clamped

## Operation
- States: IDLE, READ, DRAIN, RESPOND.
- IDLE: req_ready=1. On req_valid&&req_ready, capture req_x/req_y, go to READ with read index k=0. Later changes on req_x/req_y are ignored.
- READ, 4 cycles, k=0..3:
  - Drive mem_read_enable=1 and the address of corner k in order c00, c10, c01, c11.
  - Capture mem_data into corner k-1 when k>0.
  - After k=3, go to DRAIN.
- DRAIN, 1 cycle: mem_read_enable=0; capture corner c11; compute resp_sum; go to RESPOND.
- RESPOND: resp_valid=1; all resp_* outputs held stable. On resp_ready, go to IDLE on the next edge.
- req_ready=0 in every state except IDLE. No new request is accepted while a response is pending.
- Edge clamping:
  - x=31: x+1 is replaced by 31; resp_edge[0]=1.
  - y=15: y+1 is replaced by 15; resp_edge[1]=1.
  - Both clamp at (31,15): all four addresses equal 511.
- Arithmetic: cells are treated as unsigned. resp_sum is a zero-extended 10-bit sum with no overflow possible (max 1020).
- The block never writes the RAM. Arbitration with the write datapath is outside this block; the RAM read port is dedicated.

## Timing
- Cycle 0 is the acceptance edge (req_valid&&req_ready sampled high).
- mem_read_enable is high in cycles 1–4 and low in all other cycles.
- mem_data is sampled in cycles 2–5.
- resp_valid rises in cycle 6.
- Minimum occupancy per request is 7 cycles: 6 cycles to response, plus 1 cycle for the handshake and return to IDLE. req_ready is high the cycle after the resp handshake.
- Back-to-back operation: resp_ready held high plus req_valid held high gives one accepted request every 7 cycles.
- Reset values (in effect the cycle after reset is sampled):
  - state=IDLE, req_ready=1 (while reset is low)
  - resp_valid=0, mem_read_enable=0, mem_address=0
  - all resp_c*=0, resp_sum=0, resp_edge=0
- Reset asserted mid-READ or mid-RESPOND abandons the transaction; no response is emitted.
- While reset is high, req_ready=0.
- resp_ready is ignored outside RESPOND.

## Structure
- Shared package occupancy_pkg holds:
  - GRID_X_WIDTH, GRID_Y_WIDTH, CELL_WIDTH
  - the reader state enum
  - the clamp function for x+1/y+1
- Address formation reuses the codebase's index_to_address module. One instance is fed by a corner mux driven by k.
- The RAM instance lives in the parent. This block exposes only the read port.

## Test plan
- Interior request, (3,2), grid preloaded with cell(x,y)=x+16*y mod 256 -> addresses 67, 68, 99, 100 in cycles 1–4. Response c00=35, c10=36, c01=51, c11=52, sum=174, edge=00, resp_valid at cycle 6.
- Corner request, (31,15), cell 511=200 -> four reads of address 511. All c*=200, sum=800, edge=11.
- Edge x only, (31,0) -> addresses 31, 31, 63, 63; edge=01.
- Backpressure: resp_ready low for 5 cycles in RESPOND, new req_valid asserted -> outputs stable, req_ready=0, second request accepted only the cycle after the handshake.
- Reset at cycle 3 of a transaction -> next cycle resp_valid=0, mem_read_enable=0, req_ready=1 after reset drops. No response appears.
- Max values, all four cells=255 -> sum=1020 with no wrap.

Source files
------------

// File: rtl/occupancy_pkg.sv
// Shared definitions for the occupancy-grid read side.
//   GRID_X_WIDTH / GRID_Y_WIDTH : grid index widths (32 x 16 grid)
//   CELL_WIDTH                  : unsigned log-odds cell width
//   reader_state_t              : neighbourhood reader FSM states
//   clamp_inc()                 : idx+1, saturating at the last row/column
package occupancy_pkg;

  localparam int GRID_X_WIDTH = 5;
  localparam int GRID_Y_WIDTH = 4;
  localparam int CELL_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    DRAIN   = 2'd2,
    RESPOND = 2'd3
  } reader_state_t;

  // Widths up to 8 bits are handled; callers zero-extend and truncate back.
  function automatic logic [7:0] clamp_inc(input logic [7:0] idx, input logic [7:0] max_idx);
    return (idx >= max_idx) ? max_idx : idx + 8'd1;
  endfunction

endpackage

// File: rtl/index_to_address.sv
// Grid index to linear RAM address: address = y * 2**X_WIDTH + x, i.e. {y, x}.
//   x       in  X_WIDTH          column index
//   y       in  Y_WIDTH          row index
//   address out X_WIDTH+Y_WIDTH  linear cell address
module index_to_address #(
  parameter int X_WIDTH = 5,
  parameter int Y_WIDTH = 4
) (
  input  logic [X_WIDTH-1:0]         x,
  input  logic [Y_WIDTH-1:0]         y,
  output logic [X_WIDTH+Y_WIDTH-1:0] address
);

  assign address = {y, x};

endmodule

// File: rtl/occupancy_neighbourhood_reader.sv
// Fetches the 2x2 neighbourhood (x,y) (x+1,y) (x,y+1) (x+1,y+1) from the
// grid RAM read port and returns the four cells plus their sum in one beat.
//   clock, reset                 sole clock; synchronous active-high reset
//   req_valid/req_ready/req_x/y  request handshake and base coordinate
//   mem_read_enable/mem_address  read strobe and address to grid RAM
//   mem_data                     RAM read data, one cycle after the strobe
//   resp_valid/resp_ready        response handshake
//   resp_c00/c10/c01/c11         corner cells
//   resp_sum                     unsigned sum of the four corners
//   resp_edge                    bit0: x+1 clamped, bit1: y+1 clamped
//
// state   | meaning
// IDLE    | ready for a request
// READ    | four reads, corner k addressed, corner k-1 captured
// DRAIN   | capture last corner, form sum and edge flags
// RESPOND | response held until resp_ready
module occupancy_neighbourhood_reader #(
  parameter int X_WIDTH    = occupancy_pkg::GRID_X_WIDTH,
  parameter int Y_WIDTH    = occupancy_pkg::GRID_Y_WIDTH,
  parameter int CELL_WIDTH = occupancy_pkg::CELL_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [X_WIDTH-1:0]           req_x,
  input  logic [Y_WIDTH-1:0]           req_y,
  output logic                         mem_read_enable,
  output logic [X_WIDTH+Y_WIDTH-1:0]   mem_address,
  input  logic [CELL_WIDTH-1:0]        mem_data,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [CELL_WIDTH-1:0]        resp_c00,
  output logic [CELL_WIDTH-1:0]        resp_c10,
  output logic [CELL_WIDTH-1:0]        resp_c01,
  output logic [CELL_WIDTH-1:0]        resp_c11,
  output logic [CELL_WIDTH+1:0]        resp_sum,
  output logic [1:0]                   resp_edge
);
  import occupancy_pkg::*;

  localparam logic [X_WIDTH-1:0] X_MAX = '1;
  localparam logic [Y_WIDTH-1:0] Y_MAX = '1;
  localparam int SUM_WIDTH = CELL_WIDTH + 2;

  reader_state_t state, state_next;

  logic [1:0]                 k;
  logic [X_WIDTH-1:0]         cap_x, x_next, sel_x;
  logic [Y_WIDTH-1:0]         cap_y, y_next, sel_y;
  logic [X_WIDTH+Y_WIDTH-1:0] corner_address;

  assign x_next = X_WIDTH'(clamp_inc(8'(cap_x), 8'(X_MAX)));
  assign y_next = Y_WIDTH'(clamp_inc(8'(cap_y), 8'(Y_MAX)));

  // k order c00, c10, c01, c11: bit0 selects x+1, bit1 selects y+1.
  assign sel_x = k[0] ? x_next : cap_x;
  assign sel_y = k[1] ? y_next : cap_y;

  index_to_address #(
    .X_WIDTH (X_WIDTH),
    .Y_WIDTH (Y_WIDTH)
  ) u_index_to_address (
    .x       (sel_x),
    .y       (sel_y),
    .address (corner_address)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next      = state;
    req_ready       = 1'b0;
    mem_read_enable = 1'b0;
    mem_address     = '0;
    resp_valid      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid) state_next = READ;
      end
      READ: begin
        mem_read_enable = 1'b1;
        mem_address     = corner_address;
        if (k == 2'd3) state_next = DRAIN;
      end
      DRAIN: begin
        state_next = RESPOND;
      end
      RESPOND: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      k         <= '0;
      cap_x     <= '0;
      cap_y     <= '0;
      resp_c00  <= '0;
      resp_c10  <= '0;
      resp_c01  <= '0;
      resp_c11  <= '0;
      resp_sum  <= '0;
      resp_edge <= '0;
    end else begin
      case (state)
        IDLE: begin
          k <= '0;
          if (req_valid) begin
            cap_x <= req_x;
            cap_y <= req_y;
          end
        end
        READ: begin
          k <= k + 2'd1;
          // Read data trails the address by one cycle.
          case (k)
            2'd1:    resp_c00 <= mem_data;
            2'd2:    resp_c10 <= mem_data;
            2'd3:    resp_c01 <= mem_data;
            default: ;
          endcase
        end
        DRAIN: begin
          resp_c11  <= mem_data;
          resp_sum  <= SUM_WIDTH'(resp_c00) + SUM_WIDTH'(resp_c10)
                     + SUM_WIDTH'(resp_c01) + SUM_WIDTH'(mem_data);
          resp_edge <= {cap_y == Y_MAX, cap_x == X_MAX};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_occupancy_neighbourhood_reader.sv
module tb_occupancy_neighbourhood_reader;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_x;
  logic [3:0] req_y;
  logic       mem_read_enable;
  logic [8:0] mem_address;
  logic [7:0] mem_data;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_c00, resp_c10, resp_c01, resp_c11;
  logic [9:0] resp_sum;
  logic [1:0] resp_edge;

  int checks = 0;
  int failures = 0;

  logic [7:0] grid [512];

  always #5 clock = ~clock;

  // Synchronous-read grid RAM model.
  always @(posedge clock) begin
    if (mem_read_enable) mem_data <= grid[mem_address];
  end

  occupancy_neighbourhood_reader dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_x           (req_x),
    .req_y           (req_y),
    .mem_read_enable (mem_read_enable),
    .mem_address     (mem_address),
    .mem_data        (mem_data),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_c00        (resp_c00),
    .resp_c10        (resp_c10),
    .resp_c01        (resp_c01),
    .resp_c11        (resp_c11),
    .resp_sum        (resp_sum),
    .resp_edge       (resp_edge)
  );

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_x = '0; req_y = '0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    checks++;
    if ({resp_valid, mem_read_enable, mem_address} !== 11'd0) begin
      failures++; $display("FAIL reset_ctrl got=%b/%b/%0d exp=0/0/0", resp_valid, mem_read_enable, mem_address);
    end
    checks++;
    if ({resp_c00, resp_c10, resp_c01, resp_c11, resp_sum, resp_edge} !== 44'd0) begin
      failures++; $display("FAIL reset_resp got=%0d/%0d/%0d/%0d/%0d/%b exp=0", resp_c00, resp_c10, resp_c01, resp_c11, resp_sum, resp_edge);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
  endtask

  // Full request with cycle-exact checks; enters and leaves at a negedge in IDLE.
  task automatic do_req(input string nm, input int x, input int y,
                        input int a0, input int a1, input int a2, input int a3,
                        input int c00, input int c10, input int c01, input int c11,
                        input int sum, input int edg);
    int addr[4];
    addr = '{a0, a1, a2, a3};
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL %s idle_ready got=%b exp=1", nm, req_ready); end
    req_valid = 1'b1; req_x = 5'(x); req_y = 4'(y);
    @(negedge clock);
    req_valid = 1'b0; req_x = ~req_x; req_y = ~req_y;
    for (int p = 1; p <= 4; p++) begin
      checks++;
      if (mem_read_enable !== 1'b1 || mem_address !== 9'(addr[p-1]) || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s read_cycle%0d got en=%b addr=%0d rv=%b rr=%b exp en=1 addr=%0d rv=0 rr=0",
                 nm, p, mem_read_enable, mem_address, resp_valid, req_ready, addr[p-1]);
      end
      @(negedge clock);
    end
    checks++;
    if (mem_read_enable !== 1'b0 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL %s drain got en=%b rv=%b exp en=0 rv=0", nm, mem_read_enable, resp_valid);
    end
    @(negedge clock);
    checks++;
    if (resp_valid !== 1'b1 || mem_read_enable !== 1'b0) begin
      failures++; $display("FAIL %s resp_valid_cycle6 got rv=%b en=%b exp rv=1 en=0", nm, resp_valid, mem_read_enable);
    end
    checks++;
    if (resp_c00 !== 8'(c00) || resp_c10 !== 8'(c10) || resp_c01 !== 8'(c01) || resp_c11 !== 8'(c11)) begin
      failures++; $display("FAIL %s cells got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d",
                           nm, resp_c00, resp_c10, resp_c01, resp_c11, c00, c10, c01, c11);
    end
    checks++;
    if (resp_sum !== 10'(sum) || resp_edge !== 2'(edg)) begin
      failures++; $display("FAIL %s sum_edge got=%0d/%b exp=%0d/%b", nm, resp_sum, resp_edge, sum, 2'(edg));
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL %s after_handshake got rv=%b rr=%b exp rv=0 rr=1", nm, resp_valid, req_ready);
    end
  endtask

  task automatic test_interior();
    do_req("interior", 3, 2, 67, 68, 99, 100, 35, 36, 51, 52, 174, 0);
  endtask

  task automatic test_corner();
    grid[511] = 8'd200;
    do_req("corner", 31, 15, 511, 511, 511, 511, 200, 200, 200, 200, 800, 3);
  endtask

  task automatic test_edge_x();
    do_req("edge_x", 31, 0, 31, 31, 63, 63, 31, 31, 47, 47, 156, 1);
  endtask

  task automatic test_edge_y();
    // (4,15): rows 15 and clamped 15; cells 244, 245
    do_req("edge_y", 4, 15, 484, 485, 484, 485, 244, 245, 244, 245, 978, 2);
  endtask

  task automatic test_max();
    grid[170] = 8'd255; grid[171] = 8'd255; grid[202] = 8'd255; grid[203] = 8'd255;
    do_req("max", 10, 5, 170, 171, 202, 203, 255, 255, 255, 255, 1020, 0);
  endtask

  task automatic test_backpressure();
    int bad;
    req_valid = 1'b1; req_x = 5'd3; req_y = 4'd2;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (5) @(negedge clock);
    // period 6: response up, new request waiting
    req_valid = 1'b1; req_x = 5'd5; req_y = 4'd5;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_c00 !== 8'd35 || resp_c11 !== 8'd52 || resp_sum !== 10'd174) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL backpressure_hold got bad_cycles=%0d exp=0", bad); end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL backpressure_release got rv=%b rr=%b exp rv=0 rr=1", resp_valid, req_ready);
    end
    @(negedge clock);
    req_valid = 1'b0;
    checks++;
    if (mem_read_enable !== 1'b1 || mem_address !== 9'd165) begin
      failures++; $display("FAIL backpressure_second got en=%b addr=%0d exp en=1 addr=165", mem_read_enable, mem_address);
    end
    repeat (5) @(negedge clock);
    checks++;
    if (resp_valid !== 1'b1 || resp_c00 !== 8'd85 || resp_c11 !== 8'd102) begin
      failures++; $display("FAIL backpressure_second_resp got rv=%b c00=%0d c11=%0d exp rv=1 c00=85 c11=102", resp_valid, resp_c00, resp_c11);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    req_valid = 1'b1; req_x = 5'd3; req_y = 4'd2;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL midreset_ready_in_reset got=%b exp=0", req_ready); end
    @(negedge clock);
    checks++;
    if (resp_valid !== 1'b0 || mem_read_enable !== 1'b0 || mem_address !== 9'd0 || req_ready !== 1'b0) begin
      failures++; $display("FAIL midreset_abort got rv=%b en=%b addr=%0d rr=%b exp 0/0/0/0", resp_valid, mem_read_enable, mem_address, req_ready);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready_after got=%b exp=1", req_ready); end
    seen = 0;
    resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid !== 1'b0 || mem_read_enable !== 1'b0) seen++;
      @(negedge clock);
    end
    resp_ready = 1'b0;
    checks++;
    if (seen != 0) begin failures++; $display("FAIL midreset_no_response got active_cycles=%0d exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    int accepts[$];
    req_valid = 1'b1; resp_ready = 1'b1; req_x = 5'd3; req_y = 4'd2;
    for (int p = 0; p < 22; p++) begin
      if (req_ready === 1'b1) accepts.push_back(p);
      @(negedge clock);
    end
    req_valid = 1'b0;
    checks++;
    if (accepts.size() != 4) begin
      failures++; $display("FAIL b2b_count got=%0d exp=4", accepts.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (accepts[i] - accepts[i-1] != 7) begin
          failures++; $display("FAIL b2b_spacing%0d got=%0d exp=7", i, accepts[i] - accepts[i-1]);
        end
      end
    end
    repeat (10) @(negedge clock);
    resp_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) grid[i] = 8'((i % 32) + 16 * (i / 32));
    test_reset();
    test_interior();
    test_corner();
    test_edge_x();
    test_edge_y();
    test_max();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
